// File: rtl/wmem_loader.sv
// wmem_loader: writes a valid/ready word stream to consecutive RAM addresses from a base.
// Optional WMEM_LOADER_CHECKSUM_EN adds a readback pass that compares write and read sums.
module wmem_loader #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [ADDR_W-1:0] MEM_ADD,
  output logic              MEM_CSB,
  output logic              MEM_WEB,
  output logic              MEM_OEB,
  output logic [DATA_W-1:0] MEM_DATA_O,
  input  logic [DATA_W-1:0] MEM_DATA_I,
  output logic              busy,
  output logic              done,
  output logic              chk_err
);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StDrain,
    StVerifyRd,
    StVerifyCmp
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] add_q, add_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [ADDR_W:0]   idx_inc;
  logic              csb_q, csb_d;
  logic              web_q, web_d;
  logic              oeb_q, oeb_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              hs, last_hs, last_rd;
  logic              verify_go, last_beat;

`ifdef WMEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] wsum_q, wsum_d;
  logic [DATA_W-1:0] rsum_q, rsum_d;
  logic              rd_pend_q, rd_pend_d;
  logic              chk_err_q, chk_err_d;
`else
  logic              unused_mem_data_i;
`endif

  assign idx_inc = idx_q + 1'b1;
  assign s_ready = (state_q == StWrite) && (idx_q < cnt_q);
  assign hs      = s_valid && s_ready;
  assign last_hs = hs && (idx_inc == cnt_q);
  assign last_rd = (idx_inc == cnt_q);

`ifdef WMEM_LOADER_CHECKSUM_EN
  assign verify_go = (cnt_q != '0);
  // Read data is valid in the cycle after a read strobe; the final beat has no read behind it.
  assign last_beat = rd_pend_q && csb_q;
`else
  assign verify_go         = 1'b0;
  assign last_beat         = 1'b0;
  assign unused_mem_data_i = ^MEM_DATA_I;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (word_count == '0) ? StDrain : StWrite;
        end
      end
      StWrite: begin
        if (last_hs) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        state_d = verify_go ? StVerifyRd : StIdle;
      end
      StVerifyRd: begin
        if (last_rd) begin
          state_d = StVerifyCmp;
        end
      end
      StVerifyCmp: begin
        if (last_beat) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath next-state logic.
  always_comb begin
    base_d  = base_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    add_d   = add_q;
    wdata_d = wdata_q;
    csb_d   = 1'b1;
    web_d   = 1'b1;
    oeb_d   = 1'b1;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef WMEM_LOADER_CHECKSUM_EN
    wsum_d    = wsum_q;
    rsum_d    = rsum_q;
    chk_err_d = chk_err_q;
    rd_pend_d = ~csb_q & web_q & ~oeb_q;
    if (rd_pend_q) begin
      rsum_d = rsum_q + MEM_DATA_I;
    end
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_d = base_addr;
          cnt_d  = word_count;
          idx_d  = '0;
          busy_d = 1'b1;
`ifdef WMEM_LOADER_CHECKSUM_EN
          wsum_d    = '0;
          rsum_d    = '0;
          chk_err_d = 1'b0;
`endif
        end
      end
      StWrite: begin
        if (hs) begin
          csb_d   = 1'b0;
          web_d   = 1'b0;
          add_d   = base_q + idx_q[ADDR_W-1:0];
          wdata_d = s_data;
          idx_d   = idx_inc;
`ifdef WMEM_LOADER_CHECKSUM_EN
          wsum_d  = wsum_q + s_data;
`endif
        end
      end
      StDrain: begin
        idx_d = '0;
        if (!verify_go) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      StVerifyRd: begin
        csb_d = 1'b0;
        oeb_d = 1'b0;
        add_d = base_q + idx_q[ADDR_W-1:0];
        idx_d = idx_inc;
      end
      StVerifyCmp: begin
        if (last_beat) begin
          done_d = 1'b1;
          busy_d = 1'b0;
`ifdef WMEM_LOADER_CHECKSUM_EN
          chk_err_d = ((rsum_q + MEM_DATA_I) != wsum_q);
`endif
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      base_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      add_q   <= '0;
      wdata_q <= '0;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      oeb_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef WMEM_LOADER_CHECKSUM_EN
      wsum_q    <= '0;
      rsum_q    <= '0;
      rd_pend_q <= 1'b0;
      chk_err_q <= 1'b0;
`endif
    end else begin
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      add_q   <= add_d;
      wdata_q <= wdata_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      oeb_q   <= oeb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef WMEM_LOADER_CHECKSUM_EN
      wsum_q    <= wsum_d;
      rsum_q    <= rsum_d;
      rd_pend_q <= rd_pend_d;
      chk_err_q <= chk_err_d;
`endif
    end
  end

  assign MEM_ADD    = add_q;
  assign MEM_CSB    = csb_q;
  assign MEM_WEB    = web_q;
  assign MEM_OEB    = oeb_q;
  assign MEM_DATA_O = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifdef WMEM_LOADER_CHECKSUM_EN
  assign chk_err    = chk_err_q;
`else
  assign chk_err    = 1'b0;
`endif

endmodule

// File: tb/tb_wmem_loader.sv
// Directed bench for wmem_loader: expected writes are queued at each handshake and
// matched against the RAM bus by a negedge monitor; a RAM model backs reads.
module tb_wmem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  base_addr;
  logic [5:0]  word_count;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic [4:0]  MEM_ADD;
  logic        MEM_CSB, MEM_WEB, MEM_OEB;
  logic [31:0] MEM_DATA_O;
  logic [31:0] MEM_DATA_I;
  logic        busy, done, chk_err;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         q[$];
  logic [31:0] ram     [32];
  logic [31:0] exp_mem [32];
  int          cyc      = 0;
  int          checks   = 0;
  int          passes   = 0;
  int          fails    = 0;
  int          done_cnt = 0;
  logic        flip_en;
  logic [4:0]  flip_addr;
  logic [31:0] rdata = '0;

  wmem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .MEM_ADD    (MEM_ADD),
    .MEM_CSB    (MEM_CSB),
    .MEM_WEB    (MEM_WEB),
    .MEM_OEB    (MEM_OEB),
    .MEM_DATA_O (MEM_DATA_O),
    .MEM_DATA_I (MEM_DATA_I),
    .busy       (busy),
    .done       (done),
    .chk_err    (chk_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model; optionally corrupts bit 0 of one address on readback.
  always @(posedge clk) begin
    if (!MEM_CSB && !MEM_WEB) ram[MEM_ADD] <= MEM_DATA_O;
    if (!MEM_CSB && MEM_WEB && !MEM_OEB)
      rdata <= ram[MEM_ADD] ^ ((flip_en && MEM_ADD == flip_addr) ? 32'h1 : 32'h0);
  end
  assign MEM_DATA_I = rdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write-bus monitor: every write strobe must match the queue head, in the expected cycle.
  always @(negedge clk) begin
    wr_t e;
    if (done) done_cnt++;
    if (q.size() != 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      check("missed_wr_cyc", cyc, e.cyc);
    end
    if (!MEM_CSB && !MEM_WEB) begin
      check("wr_expected", q.size() != 0, 1'b1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("wr_addr", MEM_ADD, e.addr);
        check("wr_data", MEM_DATA_O, e.data);
        check("wr_cyc", cyc, e.cyc);
      end
    end
  end

  task automatic burst(input int base, input int cnt, input int gap, input bit midstart,
                       input bit exp_err);
    int ext;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 5'(base); word_count = 6'(cnt);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          s_valid = 1'b0; s_data = $urandom;
          if (midstart && g == 0) begin
            start = 1'b1; base_addr = 5'd17; word_count = 6'd1;
          end
          @(negedge clk);
          check("ready_gap", s_ready, 1'b1);
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
      s_valid = 1'b1; s_data = $urandom;
      q.push_back('{addr: 5'(base + i), data: s_data, cyc: cyc + 1});
      exp_mem[5'(base + i)] = s_data;
      @(negedge clk);
      check("ready_hs", s_ready, 1'b1);
      check("busy_wr", busy, 1'b1);
      check("chk_clr", chk_err, 1'b0);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    @(negedge clk);
    check("ready_drain", s_ready, 1'b0);
    check("done_drain", done, 1'b0);
    check("busy_drain", busy, 1'b1);
    ext = 0;
`ifdef WMEM_LOADER_CHECKSUM_EN
    if (cnt > 0) ext = cnt + 2;
`endif
    for (int k = 0; k < ext; k++) begin
      @(posedge clk); @(negedge clk);
      check("done_early", done, 1'b0);
    end
    @(posedge clk); @(negedge clk);
    check("done_pulse", done, 1'b1);
    check("busy_done", busy, 1'b0);
    check("chk_err_done", chk_err, exp_err);
    @(posedge clk); @(negedge clk);
    check("done_once", done, 1'b0);
    check("chk_err_sticky", chk_err, exp_err);
    check("queue_empty", q.size(), 0);
    for (int i = 0; i < cnt; i++) check("ram_data", ram[5'(base + i)], exp_mem[5'(base + i)]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int d0;
    rst = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    s_valid = 1'b0; s_data = '0; flip_en = 1'b0; flip_addr = '0;

    // Reset held for 3 cycles with random inputs.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      start = 1'($urandom); base_addr = 5'($urandom); word_count = 6'($urandom);
      s_valid = 1'($urandom); s_data = $urandom;
      @(negedge clk);
      check("rst_csb", MEM_CSB, 1'b1);
      check("rst_web", MEM_WEB, 1'b1);
      check("rst_oeb", MEM_OEB, 1'b1);
      check("rst_add", MEM_ADD, 5'd0);
      check("rst_dout", MEM_DATA_O, 32'd0);
      check("rst_ready", s_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_chk", chk_err, 1'b0);
    end
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0; s_valid = 1'b0;

    burst(4, 3, 0, 1'b0, 1'b0);     // back-to-back
    burst(8, 4, 2, 1'b1, 1'b0);     // gaps plus ignored mid-burst start
    burst(30, 4, 0, 1'b0, 1'b0);    // address wrap
    d0 = done_cnt;
    burst(0, 0, 0, 1'b0, 1'b0);     // empty burst
    check("empty_done_count", done_cnt - d0, 1);
    burst(0, 32, 0, 1'b0, 1'b0);    // full memory
    burst(5, 3, 1, 1'b0, 1'b0);

    // Reset after 2 of 5 words.
    @(posedge clk); #1;
    start = 1'b1; base_addr = 5'd10; word_count = 6'd5;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_data = $urandom;
      q.push_back('{addr: 5'(10 + i), data: s_data, cyc: cyc + 1});
      exp_mem[5'(10 + i)] = s_data;
      @(posedge clk); #1;
    end
    rst = 1'b0; d0 = done_cnt;
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    check("mrst_csb", MEM_CSB, 1'b1);
    check("mrst_web", MEM_WEB, 1'b1);
    check("mrst_busy", busy, 1'b0);
    check("mrst_ready", s_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 8; k++) @(posedge clk);
    @(negedge clk);
    check("mrst_no_done", done_cnt - d0, 0);
    check("mrst_queue", q.size(), 0);
    check("mrst_ram0", ram[10], exp_mem[10]);
    check("mrst_ram1", ram[11], exp_mem[11]);
    burst(20, 2, 1, 1'b0, 1'b0);

`ifdef WMEM_LOADER_CHECKSUM_EN
    flip_en = 1'b1; flip_addr = 5'd13;
    burst(12, 3, 0, 1'b0, 1'b1);    // corrupted readback
    flip_en = 1'b0;
    burst(12, 3, 1, 1'b0, 1'b0);    // clean again, error cleared
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/wmem_loader.md
Name: wmem_loader

Overview:
- Write-side initiator for one port of a dpram32x32_cb kernel or weight memory.
- Accepts a valid/ready stream of 32-bit words and writes them to consecutive addresses starting at a programmed base.
- Pulses done when the burst is complete.
- Drives memory contents that the neural-net controller later reads back for the CNeuron and FC layers.

Parameters:
- ADDR_W, 5, memory address width; the address space is 2**ADDR_W words.
- DATA_W, 32, memory word width.

Ports:
- clk  in  1  system clock; also drives the RAM CEB pin.
- rst  in  1  synchronous reset, active-low.
- start  in  1  begin a burst; sampled only in IDLE.
- base_addr  in  ADDR_W  first write address; latched on start.
- word_count  in  ADDR_W+1  number of words, 0..2**ADDR_W; latched on start.
- s_valid  in  1  stream word valid.
- s_data  in  DATA_W  stream word.
- s_ready  out  1  loader can accept a word.
- MEM_ADD  out  ADDR_W  RAM address.
- MEM_CSB  out  1  RAM chip select, active-low.
- MEM_WEB  out  1  RAM write enable, active-low.
- MEM_OEB  out  1  RAM output enable, active-low.
- MEM_DATA_O  out  DATA_W  RAM write data (drives I1/I2).
- MEM_DATA_I  in  DATA_W  RAM read data (from O1/O2); used only with the optional feature.
- busy  out  1  burst in progress.
- done  out  1  one-cycle completion pulse.
- chk_err  out  1  readback checksum mismatch; sticky until the next start.

Behaviour:
- Reset (rst==0 at a clk edge):
  - FSM goes to IDLE.
  - MEM_CSB=MEM_WEB=MEM_OEB=1; MEM_ADD=0; MEM_DATA_O=0.
  - s_ready=0, busy=0, done=0, chk_err=0.
  - Applies mid-burst as well: the burst is abandoned with no further strobes and no done.
- RAM protocol:
  - Write occurs at the clk edge where CSB=0 and WEB=0.
  - Read issues at the edge where CSB=0, WEB=1, OEB=0; MEM_DATA_I is valid one cycle later.
- All memory outputs are registered. The idle memory state is CSB=WEB=OEB=1.
- States: IDLE, WRITE, DRAIN, then VERIFY_RD and VERIFY_CMP (feature only), then back to IDLE.
- IDLE:
  - start=1 latches base_addr and word_count, clears chk_err, sets busy=1.
  - If word_count==0: next state DRAIN.
  - Otherwise: next state WRITE.
  - start while busy is ignored.
- WRITE:
  - s_ready=1 while the accepted count < word_count.
  - A handshake at edge t (s_valid & s_ready) produces, during cycle t+1: MEM_CSB=0, MEM_WEB=0, MEM_ADD=base+i (mod 2**ADDR_W), MEM_DATA_O=s_data.
  - If no handshake at t, strobes return to 1 in cycle t+1.
  - Back-to-back handshakes give back-to-back writes; gaps in s_valid give gaps in strobes.
  - s_ready drops in the cycle after the last handshake; next state DRAIN.
- DRAIN:
  - One cycle with the last write strobe on the bus; strobes return to 1 afterwards.
  - Then: next state VERIFY_RD if the feature is compiled in and word_count>0.
  - Otherwise: done=1 for one cycle, busy=0, next state IDLE.
  - For word_count==0: done pulses two cycles after the start edge, with no memory strobe.
- Address arithmetic: ADDR_W-bit wrap, so base=30, count=4 gives addresses 30, 31, 0, 1.
- s_data is don't-care whenever s_ready=0.

Optional Feature:
- Macro: WMEM_LOADER_CHECKSUM_EN.
- Defined:
  - Each accepted word is added into a DATA_W-bit checksum (mod 2**DATA_W).
  - VERIFY_RD issues one read per cycle at base..base+count-1 with CSB=0, WEB=1, OEB=0.
  - MEM_DATA_I is accumulated one cycle after each read.
  - VERIFY_CMP follows the last data beat and compares the two sums. On mismatch, chk_err=1 in the same cycle as done.
  - done is delayed by count+2 cycles relative to the undefined build.
- Undefined:
  - No verify states; chk_err is tied 0.
  - MEM_DATA_I is ignored; MEM_OEB stays 1.

Test Plan:
- Reset: hold rst=0 for 3 cycles with random inputs -> all strobes 1, s_ready=0, busy=0, done=0, chk_err=0.
- Burst: base=4, count=3, words 0x11,0x22,0x33 streamed back-to-back -> writes at 4,5,6 in consecutive cycles; done one cycle after the DRAIN cycle; RAM model holds the data.
- Backpressure: count=4 with s_valid low for 2 cycles between words -> strobe gaps exactly match the gaps; addresses stay sequential; start pulsed mid-burst has no effect.
- Boundaries:
  - base=30, count=4 -> addresses 30,31,0,1.
  - count=0 -> done pulses 2 cycles after start, CSB never 0.
  - count=32 -> all addresses written once.
- Reset mid-burst: rst=0 after 2 of 5 words -> strobes return to 1 the next cycle, no done; a new burst afterwards works normally.
- Checksum (macro defined):
  - Clean RAM model -> chk_err=0.
  - RAM model flips bit 0 of word 1 on read -> chk_err=1, asserted together with done, and cleared on the next start.
